// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//   Polyphonic voice allocator for a PS/2 keyboard synthesizer. Key events come
//   in as an 11-bit word whose bit 10 toggles once per event. A mapped press
//   claims a voice, which then runs an attack/sustain/release volume envelope.
//   The envelope advances once every TICK_DIV clock cycles.
//
// Ports
//   clk           : single clock; all logic runs on its rising edge
//   reset         : synchronous, active-high reset
//   ps2_key       : [10] event toggle, [9] 1=press/0=release, [8] extended,
//                   [7:0] set-2 scancode
//   frequencies   : VOICES x 32, voice i at [i*32 +: 32], note frequency in Hz
//   voice_volumes : VOICES x 32, voice i at [i*32 +: 32], envelope volume
//   active        : per voice, 1 when the voice is not IDLE
//   drop          : one-cycle pulse when a press finds no voice to use
//   dbg_state     : per voice envelope state at [i*2 +: 2]
//                   (0 IDLE, 1 ATTACK, 2 SUSTAIN, 3 RELEASE)
//
// Handshake: there is no valid/ready pair. A key event is accepted on the
//   first rising edge at which ps2_key[10] differs from the stored copy. The
//   result is visible on the outputs right after that edge.
// -----------------------------------------------------------------------------
module voice_allocator #(
  parameter int unsigned VOICES       = 8,
  parameter int unsigned VOL_MAX      = 65535,
  parameter int unsigned ATTACK_STEP  = 256,
  parameter int unsigned RELEASE_STEP = 64,
  parameter int unsigned TICK_DIV     = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          ps2_key,
  output logic [VOICES*32-1:0] frequencies,
  output logic [VOICES*32-1:0] voice_volumes,
  output logic [VOICES-1:0]    active,
  output logic                 drop,
  output logic [VOICES*2-1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } voice_state_e;

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  voice_state_e state_q [VOICES];
  voice_state_e state_d [VOICES];
  logic [3:0]   note_q  [VOICES];
  logic [3:0]   note_d  [VOICES];
  logic [31:0]  freq_q  [VOICES];
  logic [31:0]  freq_d  [VOICES];
  logic [31:0]  vol_q   [VOICES];
  logic [31:0]  vol_d   [VOICES];

  logic          tog_q;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          drop_q, drop_d;
  logic          tick;

  // Scancode decode
  logic        note_hit;
  logic [3:0]  ev_note;
  logic [31:0] ev_freq;
  logic        ev_valid;

  always_comb begin
    note_hit = 1'b1;
    ev_note  = 4'd0;
    ev_freq  = 32'd0;
    case (ps2_key[7:0])
      8'h1C: begin ev_note = 4'd0;  ev_freq = 32'd262; end
      8'h1D: begin ev_note = 4'd1;  ev_freq = 32'd277; end
      8'h1B: begin ev_note = 4'd2;  ev_freq = 32'd294; end
      8'h24: begin ev_note = 4'd3;  ev_freq = 32'd311; end
      8'h23: begin ev_note = 4'd4;  ev_freq = 32'd330; end
      8'h2B: begin ev_note = 4'd5;  ev_freq = 32'd349; end
      8'h2C: begin ev_note = 4'd6;  ev_freq = 32'd370; end
      8'h34: begin ev_note = 4'd7;  ev_freq = 32'd392; end
      8'h35: begin ev_note = 4'd8;  ev_freq = 32'd415; end
      8'h33: begin ev_note = 4'd9;  ev_freq = 32'd440; end
      8'h3C: begin ev_note = 4'd10; ev_freq = 32'd466; end
      8'h3B: begin ev_note = 4'd11; ev_freq = 32'd494; end
      8'h42: begin ev_note = 4'd12; ev_freq = 32'd523; end
      default: note_hit = 1'b0;
    endcase
  end

  // Extended codes share scancodes with ordinary keys, so they are ignored.
  assign ev_valid = (ps2_key[10] != tog_q) && !ps2_key[8] && note_hit;
  assign tick     = (tick_cnt_q == CW'(TICK_DIV - 1));

  logic [VOICES-1:0] held_mask;
  logic              idle_found, rel_found, alloc_en;
  int                idle_idx, rel_idx, alloc_idx;
  logic [32:0]       att_sum;

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    drop_d     = 1'b0;
    held_mask  = '0;
    idle_found = 1'b0;
    rel_found  = 1'b0;
    idle_idx   = 0;
    rel_idx    = 0;
    alloc_en   = 1'b0;
    alloc_idx  = 0;
    att_sum    = '0;

    for (int i = 0; i < int'(VOICES); i++) begin
      held_mask[i] = (state_q[i] inside {ST_ATTACK, ST_SUSTAIN}) &&
                     (note_q[i] == ev_note);
    end

    // Scanning from the top down leaves the lowest matching index.
    for (int i = int'(VOICES) - 1; i >= 0; i--) begin
      if (state_q[i] == ST_IDLE) begin
        idle_found = 1'b1;
        idle_idx   = i;
      end
      if (state_q[i] == ST_RELEASE) begin
        rel_found = 1'b1;
        rel_idx   = i;
      end
    end

    // A press of a note that is already held is a typematic repeat.
    if (ev_valid && ps2_key[9] && (held_mask == '0)) begin
      if (idle_found) begin
        alloc_en  = 1'b1;
        alloc_idx = idle_idx;
      end else if (rel_found) begin
        alloc_en  = 1'b1;
        alloc_idx = rel_idx;
      end else begin
        drop_d = 1'b1;
      end
    end

    for (int i = 0; i < int'(VOICES); i++) begin
      state_d[i] = state_q[i];
      note_d[i]  = note_q[i];
      freq_d[i]  = freq_q[i];
      vol_d[i]   = vol_q[i];

      // Envelope step; overridden below when an event lands on this voice.
      if (tick) begin
        case (state_q[i])
          ST_ATTACK: begin
            att_sum = {1'b0, vol_q[i]} + 33'(ATTACK_STEP);
            if (att_sum >= 33'(VOL_MAX)) begin
              vol_d[i]   = VOL_MAX;
              state_d[i] = ST_SUSTAIN;
            end else begin
              vol_d[i] = att_sum[31:0];
            end
          end
          ST_SUSTAIN: vol_d[i] = VOL_MAX;
          ST_RELEASE: begin
            if (vol_q[i] <= 32'(RELEASE_STEP)) begin
              vol_d[i]   = '0;
              freq_d[i]  = '0;
              state_d[i] = ST_IDLE;
            end else begin
              vol_d[i] = vol_q[i] - 32'(RELEASE_STEP);
            end
          end
          default: ;
        endcase
      end

      if (alloc_en && (i == alloc_idx)) begin
        state_d[i] = ST_ATTACK;
        note_d[i]  = ev_note;
        freq_d[i]  = ev_freq;
        vol_d[i]   = '0;
      end

      // Release keeps the volume reached so far.
      if (ev_valid && !ps2_key[9] && held_mask[i]) begin
        state_d[i] = ST_RELEASE;
        vol_d[i]   = vol_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    // The toggle copy is loaded during reset as well, so no stale event
    // fires on the first cycle after reset is released.
    tog_q <= ps2_key[10];
    if (reset) begin
      tick_cnt_q <= '0;
      drop_q     <= 1'b0;
      for (int i = 0; i < int'(VOICES); i++) begin
        state_q[i] <= ST_IDLE;
        note_q[i]  <= '0;
        freq_q[i]  <= '0;
        vol_q[i]   <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      drop_q     <= drop_d;
      for (int i = 0; i < int'(VOICES); i++) begin
        state_q[i] <= state_d[i];
        note_q[i]  <= note_d[i];
        freq_q[i]  <= freq_d[i];
        vol_q[i]   <= vol_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(VOICES); g++) begin : g_out
    assign frequencies[g*32 +: 32]   = freq_q[g];
    assign voice_volumes[g*32 +: 32] = vol_q[g];
    assign active[g]                 = (state_q[g] != ST_IDLE);
    assign dbg_state[g*2 +: 2]       = state_q[g];
  end

  assign drop = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
//   Directed bench for voice_allocator with default parameters. Expected
//   values are pushed to exp_q when a step is driven. They are popped and
//   compared against the DUT once the step's clock edge has passed.
// -----------------------------------------------------------------------------
module tb_voice_allocator;

  localparam int VOICES = 8;
  localparam int W      = 32;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ATTACK  = 2'd1;
  localparam logic [1:0] S_SUSTAIN = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic                 clk;
  logic                 reset;
  logic [10:0]          ps2_key;
  logic [VOICES*32-1:0] frequencies;
  logic [VOICES*32-1:0] voice_volumes;
  logic [VOICES-1:0]    active;
  logic                 drop;
  logic [VOICES*2-1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  voice_allocator #(
    .VOICES      (VOICES),
    .VOL_MAX     (65535),
    .ATTACK_STEP (256),
    .RELEASE_STEP(64),
    .TICK_DIV    (48)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_key      (ps2_key),
    .frequencies  (frequencies),
    .voice_volumes(voice_volumes),
    .active       (active),
    .drop         (drop),
    .dbg_state    (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change #1 after a rising edge, and outputs are
  // sampled at that same point.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic press, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], press, ext, code};
    step(1);
  endtask

  function automatic logic [31:0] freq_of(input int v);
    return frequencies[v*32 +: 32];
  endfunction

  function automatic logic [31:0] vol_of(input int v);
    return voice_volumes[v*32 +: 32];
  endfunction

  function automatic logic [31:0] st_of(input int v);
    return {30'd0, dbg_state[v*2 +: 2]};
  endfunction

  // Scoreboard
  task automatic expect_val(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %0d but the expected queue is empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [7:0] codes [9];
  int         hz    [9];

  initial begin
    codes = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35};
    hz    = '{262, 277, 294, 311, 330, 349, 370, 392, 415};

    reset   = 1'b1;
    ps2_key = 11'd0;
    step(3);
    expect_val(0); check("rst_freq",   {31'd0, |frequencies});
    expect_val(0); check("rst_vol",    {31'd0, |voice_volumes});
    expect_val(0); check("rst_active", {24'd0, active});
    expect_val(0); check("rst_drop",   {31'd0, drop});
    reset = 1'b0;
    step(2 + $urandom_range(0, 47));

    // Single note: attack to sustain
    send(1'b1, 1'b0, 8'h1C);
    expect_val(262);      check("p1_freq0",   freq_of(0));
    expect_val(S_ATTACK); check("p1_state0",  st_of(0));
    expect_val(8'h01);    check("p1_active",  {24'd0, active});
    expect_val(0);        check("p1_vol0",    vol_of(0));
    step(48 * 128);
    expect_val(32768);    check("att_half_vol", vol_of(0));
    expect_val(S_ATTACK); check("att_half_st",  st_of(0));
    step(48 * 128);
    expect_val(65535);     check("att_done_vol", vol_of(0));
    expect_val(S_SUSTAIN); check("att_done_st",  st_of(0));

    // Ignored events: typematic repeat, extended code, unmapped code
    send(1'b1, 1'b0, 8'h1C);
    expect_val(S_SUSTAIN); check("rep_state0", st_of(0));
    expect_val(8'h01);     check("rep_active", {24'd0, active});
    send(1'b1, 1'b1, 8'h1D);
    expect_val(8'h01);     check("ext_active", {24'd0, active});
    send(1'b1, 1'b0, 8'h15);
    expect_val(8'h01);     check("unmap_active", {24'd0, active});
    expect_val(0);         check("unmap_drop",   {31'd0, drop});
    send(1'b0, 1'b0, 8'h1D);
    expect_val(S_SUSTAIN); check("rel_unheld_st", st_of(0));
    expect_val(65535);     check("sus_vol", vol_of(0));

    // Release to idle
    send(1'b0, 1'b0, 8'h1C);
    expect_val(S_RELEASE); check("rel_state0", st_of(0));
    expect_val(65535);     check("rel_vol0",   vol_of(0));
    step(48 * 512);
    expect_val(32767);     check("rel_half_vol", vol_of(0));
    step(48 * 512);
    expect_val(0);         check("rel_done_vol",  vol_of(0));
    expect_val(0);         check("rel_done_freq", freq_of(0));
    expect_val(S_IDLE);    check("rel_done_st",   st_of(0));
    expect_val(0);         check("rel_done_act",  {24'd0, active});

    // Eight held notes fill every voice; the ninth press is dropped
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0, codes[i]);
    expect_val(8'hFF); check("full_active", {24'd0, active});
    expect_val(0);     check("full_drop",   {31'd0, drop});
    send(1'b1, 1'b0, codes[8]);
    expect_val(1);     check("ninth_drop",   {31'd0, drop});
    expect_val(8'hFF); check("ninth_active", {24'd0, active});
    for (int i = 0; i < 8; i++) begin
      expect_val(hz[i]); check($sformatf("ninth_freq%0d", i), freq_of(i));
    end
    step(1);
    expect_val(0);     check("drop_pulse_end", {31'd0, drop});

    // A releasing voice is reused when nothing is idle
    send(1'b0, 1'b0, 8'h1C);
    expect_val(S_RELEASE); check("steal_rel_st", st_of(0));
    send(1'b1, 1'b0, 8'h42);
    expect_val(523);       check("steal_freq0",  freq_of(0));
    expect_val(0);         check("steal_vol0",   vol_of(0));
    expect_val(S_ATTACK);  check("steal_state0", st_of(0));
    expect_val(0);         check("steal_drop",   {31'd0, drop});
    expect_val(392);       check("steal_freq7",  freq_of(7));

    // Reset mid-envelope; toggle flips while reset is held
    reset   = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1D};
    step(1);
    expect_val(0); check("midrst_active", {24'd0, active});
    expect_val(0); check("midrst_vol",    {31'd0, |voice_volumes});
    step(60);
    expect_val(0); check("midrst_hold_vol",  {31'd0, |voice_volumes});
    expect_val(0); check("midrst_hold_freq", {31'd0, |frequencies});
    reset = 1'b0;
    step(3);
    expect_val(0); check("post_rst_active", {24'd0, active});
    expect_val(0); check("post_rst_freq",   {31'd0, |frequencies});
    expect_val(0); check("post_rst_drop",   {31'd0, drop});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter VOICES, default 8: number of synthesizer voices.
REQ-002 SHALL have parameter VOL_MAX, default 65535: sustain volume.
REQ-003 SHALL have parameter ATTACK_STEP, default 256: volume increment per envelope tick.
REQ-004 SHALL have parameter RELEASE_STEP, default 64: volume decrement per envelope tick.
REQ-005 SHALL have parameter TICK_DIV, default 48: clk cycles per envelope tick.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port ps2_key, input, 11: [10] toggles per key event, [9] 1=press/0=release, [8] extended, [7:0] set-2 scancode.
REQ-009 SHALL have port frequencies, output, VOICES x 32: note frequency per voice in integer Hz.
REQ-010 SHALL have port voice_volumes, output, VOICES x 32: envelope volume per voice, unsigned.
REQ-011 SHALL have port active, output, VOICES: 1 = voice not IDLE.
REQ-012 SHALL have port drop, output, 1: one-cycle pulse when a press finds no voice.

Function
REQ-013 SHALL detect an event at a rising edge where ps2_key[10] differs from its stored copy, then update the copy; at most one event per cycle.
REQ-014 SHALL ignore events with ps2_key[8]=1 or a scancode outside the map in REQ-015.
REQ-015 SHALL map scancodes 1C,1D,1B,24,23,2B,2C,34,35,33,3C,3B,42 to notes 0-12, with Hz 262,277,294,311,330,349,370,392,415,440,466,494,523.
REQ-016 SHALL give each voice state IDLE, ATTACK, SUSTAIN or RELEASE, plus a 4-bit note, a 32-bit frequency and a 32-bit volume.
REQ-017 Press of a note already held by a voice in ATTACK or SUSTAIN SHALL be ignored (typematic repeat).
REQ-018 On any other press, the allocator SHALL take the lowest-index IDLE voice, else the lowest-index RELEASE voice, else none and pulse drop.
REQ-019 The allocated voice SHALL load note and frequency, set volume to 0 and enter ATTACK at the event edge.
REQ-020 Release of a note SHALL move the voice holding it in ATTACK or SUSTAIN to RELEASE, keeping its volume; release of an unheld note SHALL be ignored.
REQ-021 A tick counter SHALL count 0..TICK_DIV-1 and assert a tick in the cycle it wraps to 0.
REQ-022 On tick, each ATTACK voice SHALL add ATTACK_STEP with saturation; on reaching VOL_MAX it SHALL enter SUSTAIN.
REQ-023 On tick, each RELEASE voice SHALL subtract RELEASE_STEP; if volume <= RELEASE_STEP it SHALL set volume 0, frequency 0 and enter IDLE.
REQ-024 SUSTAIN voices SHALL hold volume VOL_MAX.
REQ-025 When an event and a tick coincide on the same voice, the event SHALL take precedence and that voice's envelope step SHALL be skipped that tick.
REQ-026 Outputs SHALL be registered and reflect voice registers one cycle after the causing edge's inputs (latency 1 from ps2_key change).
REQ-027 The active bit SHALL equal (state != IDLE) for each voice.

Reset
REQ-028 Reset SHALL set all voices IDLE, with frequencies 0, volumes 0, active 0, drop 0 and tick counter 0.
REQ-029 During reset, the stored toggle copy SHALL load ps2_key[10], so no event is generated at reset release.
REQ-030 Reset asserted mid-attack or mid-release SHALL abort the envelope immediately, with no further output change until reset is deasserted.

Verification
REQ-031 Toggle with press 1C -> voice0 frequency=262, ATTACK, active=0x01; volume=65535 after 256 ticks (12288 cycles), then SUSTAIN.
REQ-032 Release 1C while in SUSTAIN -> RELEASE; volume=0, frequency=0, IDLE after 1024 ticks.
REQ-033 Nine distinct presses, all held -> voices 0-7 get notes 0-7; the ninth press pulses drop for 1 cycle and leaves all voices unchanged.
REQ-034 With voice0 in RELEASE, voices 1-7 held, press 42 -> voice0 reloads 523, volume 0, ATTACK.
REQ-035 Repeat press 1C while held, extended press 1C, and unmapped code 15 -> no state change; reset with toggle=1 -> no event after release.
